// File: rtl/arm_mem_arbiter.sv
// Two-requester round-robin arbiter that sequences word-aligned accesses onto one
// arm_memory port and returns load data and an exception flag to the winner.
module arm_mem_arbiter #(
   parameter int MEM_LATENCY = 1,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              r0_req,
   input  logic              r0_write,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   output logic              r0_gnt,
   output logic              r0_done,
   output logic [DATA_W-1:0] r0_rdata,
   output logic              r0_excpt,
   input  logic              r1_req,
   input  logic              r1_write,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r1_gnt,
   output logic              r1_done,
   output logic [DATA_W-1:0] r1_rdata,
   output logic              r1_excpt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_excpt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t            state;
   state_t            state_nx;
   logic              rr_ptr;
   logic              sel;
   logic              lat_write;
   logic              misalign;
   logic [3:0]        cnt;
   logic              cnt_zero;
   logic              take;
   logic              pick;
   logic              pick_write;
   logic              pick_aligned;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] pick_wdata;

   // rr_ptr names the requester that wins a tie (0 = r0, 1 = r1).
   always_comb begin
      pick = 1'b0;
      if (r0_req && r1_req) begin
         pick = rr_ptr;
      end else if (r1_req) begin
         pick = 1'b1;
      end
      pick_addr    = pick ? r1_addr  : r0_addr;
      pick_wdata   = pick ? r1_wdata : r0_wdata;
      pick_write   = pick ? r1_write : r0_write;
      pick_aligned = (pick_addr[1:0] == 2'b00);
   end

   assign cnt_zero = (cnt == 4'd0);

   always_comb begin
      state_nx = state;
      take     = 1'b0;
      case (state)
         IDLE: begin
            if (r0_req || r1_req) begin
               take     = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // A misaligned access spends one ACCESS cycle with the memory port left idle,
   // so its done pulse lands two cycles after acceptance like a 1-cycle access.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr    <= 1'b0;
         sel       <= 1'b0;
         lat_write <= 1'b0;
         misalign  <= 1'b0;
         cnt       <= 4'd0;
         r0_gnt    <= 1'b0;
         r1_gnt    <= 1'b0;
         r0_done   <= 1'b0;
         r1_done   <= 1'b0;
         r0_rdata  <= '0;
         r1_rdata  <= '0;
         r0_excpt  <= 1'b0;
         r1_excpt  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_write <= 1'b0;
      end else begin
         r0_gnt  <= take & ~pick;
         r1_gnt  <= take & pick;
         r0_done <= 1'b0;
         r1_done <= 1'b0;
         if (take) begin
            sel       <= pick;
            lat_write <= pick_write;
            misalign  <= ~pick_aligned;
            cnt       <= pick_aligned ? CNT_INIT : 4'd0;
            if (pick_aligned) begin
               mem_addr  <= pick_addr;
               mem_wdata <= pick_wdata;
               mem_write <= pick_write;
            end
         end else if (state == ACCESS) begin
            if (!cnt_zero) begin
               cnt <= cnt - 4'd1;
            end else begin
               mem_write <= 1'b0;
               if (sel) begin
                  r1_done  <= 1'b1;
                  r1_excpt <= misalign | mem_excpt;
                  if (!lat_write) begin
                     r1_rdata <= misalign ? '0 : mem_rdata;
                  end
               end else begin
                  r0_done  <= 1'b1;
                  r0_excpt <= misalign | mem_excpt;
                  if (!lat_write) begin
                     r0_rdata <= misalign ? '0 : mem_rdata;
                  end
               end
            end
         end else if (state == DONE) begin
            rr_ptr <= ~sel;
         end
      end
   end

endmodule
